dice_pip_display: RTL
=====================

# dice_pip_display

Display-side consumer of the digital dice result. Accepts a 3-bit dice value with a one-cycle valid strobe from the roll logic. Plays a decelerating "tumbling" animation across faces 1..6, then settles on the received face and drives a 7-LED pip array. Out-of-range values (0, 7) are flagged and shown as a blinking all-on pattern.

## Interface
- TICK_DIV, default 1_000_000: base dwell in clock cycles per animation step; legal range ≥1.
- ROLL_STEPS, default 12: number of tumbling steps before settling; legal range ≥1.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0); clears all state immediately.
- dice_valid  input  1  one-cycle strobe; dice_in is sampled on the same edge.
- dice_in  input  3  dice value; legal values 1..6.
- pips  output  7  LED pattern: bit0 TL, bit1 TR, bit2 ML, bit3 C, bit4 MR, bit5 BL, bit6 BR.
- face  output  3  face currently shown: 1..6 while rolling or settled, 0 in IDLE or ERROR.
- busy  output  1  high while the animation runs.
- done  output  1  one-cycle pulse when the display settles on the final face.
- error  output  1  high while in ERROR.

## Operation
- States are IDLE, ROLL, SHOW and ERROR. Reset forces IDLE with pips=0, face=0, busy=0, done=0 and error=0.
- Pip map:
  - 1 = 7'b0001000
  - 2 = 7'b1000001
  - 3 = 7'b1001001
  - 4 = 7'b1100011
  - 5 = 7'b1101011
  - 6 = 7'b1110111
- pips always equals map(face) in ROLL and SHOW.
- Load: dice_valid=1 in IDLE, SHOW or ERROR is accepted on that edge.
  - If dice_in is in 1..6: latch the target, go to ROLL, set face=1, step=0, dwell counter=0.
  - If dice_in is 0 or 7: go to ERROR.
- ROLL: busy=1.
  - Step k (0-based) lasts TICK_DIV*(k+1) cycles.
  - At the end of each step except the last, face advances by one and wraps 6→1.
  - At the end of step ROLL_STEPS-1, go to SHOW with face=target and done=1 for exactly that one cycle.
- dice_valid during ROLL is ignored. The target and the animation are unaffected; no queuing.
- SHOW: busy=0; face and pips hold until the next accepted load.
- ERROR: error=1, face=0, busy=0.
  - pips alternates between 7'h7F and 7'h00, each phase lasting 4*TICK_DIV cycles.
  - The first phase is 7'h7F.
  - A valid load exits ERROR: error drops on the same edge that enters ROLL.
  - An invalid load restarts the blink phase.
- Dwell counter is sized to hold TICK_DIV*ROLL_STEPS-1; the step counter is sized to hold ROLL_STEPS-1; neither may overflow.

## Timing
- All outputs are registered.
- Load at edge E: face=1, busy=1 and pips=map(1) are visible after E.
- Total roll length is TICK_DIV*ROLL_STEPS*(ROLL_STEPS+1)/2 cycles after E. The SHOW transition and the done pulse occur on the edge ending the last dwell.
- Back-to-back: dice_valid on the same edge that SHOW is entered is ignored, because the state is still ROLL at that edge. It is accepted from the following cycle onward.
- Reset mid-ROLL or mid-ERROR:
  - All outputs go to their reset values asynchronously.
  - The first load after reset deassertion behaves as from IDLE.
- ERROR blink: the first 7'h7F phase starts the cycle after the accepting edge.

## Test plan
All scenarios use TICK_DIV=2 and ROLL_STEPS=3, so the roll lasts 12 cycles.
- Reset, then idle: pips=0, face=0, busy=0, done=0, error=0 held indefinitely.
- Load dice_in=4:
  - face sequence is 1 (2 cycles), 2 (4 cycles), 3 (6 cycles).
  - Then face=4, pips=7'b1100011, busy=0 and done=1 for one cycle, 12 cycles after load.
- Load 6, then dice_valid with dice_in=2 at cycle 5 of the roll: the roll still settles on 6 (pips=7'b1110111) at cycle 12 with a single done pulse.
- Load 7:
  - error=1, face=0.
  - pips is 7'h7F for 8 cycles, then 7'h00 for 8 cycles, repeating.
  - A subsequent load of 1 clears error and settles on pips=7'b0001000 12 cycles later.
- Load 3, drive reset low at cycle 6: all outputs are 0 immediately. Release reset and load 5: settles on 7'b1101011 after 12 cycles.
- Every face 1..6 loaded from SHOW back-to-back: each settles on the correct map value. The face wrap 6→1 is exercised using ROLL_STEPS=8.

Source files
------------

// File: rtl/dice_pip_display.sv
// Display-side consumer of the dice result: tumbling animation with a decelerating
// dwell per step, then settles on the received face; out-of-range values blink all pips.
module dice_pip_display #(
   parameter int TICK_DIV   = 1_000_000,
   parameter int ROLL_STEPS = 12
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dice_valid,
   input  logic [2:0] dice_in,
   output logic [6:0] pips,
   output logic [2:0] face,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam int ROLL_CYC  = TICK_DIV * ROLL_STEPS;
   localparam int BLINK_CYC = 4 * TICK_DIV;
   localparam int DWELL_MAX = (ROLL_CYC > BLINK_CYC) ? ROLL_CYC : BLINK_CYC;
   localparam int DWELL_W   = $clog2(DWELL_MAX);
   localparam int STEP_W    = (ROLL_STEPS > 1) ? $clog2(ROLL_STEPS) : 1;
   localparam logic [31:0] TICK_U     = 32'(TICK_DIV);
   localparam logic [31:0] LAST_STEP  = 32'(ROLL_STEPS - 1);
   localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROLL  = 2'd1,
      ST_SHOW  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   function automatic logic [6:0] pip_map(input logic [2:0] f);
      logic [6:0] p;
      case (f)
         3'd1:    p = 7'b0001000;
         3'd2:    p = 7'b1000001;
         3'd3:    p = 7'b1001001;
         3'd4:    p = 7'b1100011;
         3'd5:    p = 7'b1101011;
         3'd6:    p = 7'b1110111;
         default: p = 7'b0000000;
      endcase
      return p;
   endfunction

   state_t               state_r, state_s;
   logic [2:0]           target_r, target_s;
   logic [2:0]           face_r, face_s;
   logic [6:0]           pips_r, pips_s;
   logic                 busy_r, busy_s;
   logic                 done_r, done_s;
   logic                 error_r, error_s;
   logic [STEP_W-1:0]    step_r, step_s;
   logic [DWELL_W-1:0]   dwell_r, dwell_s;
   logic [31:0]          dwell_ext_s;
   logic [31:0]          step_limit_s;
   logic [2:0]           face_inc_s;
   logic                 legal_s;

   // Step k ends once the dwell counter reaches TICK_DIV*(k+1)-1.
   assign dwell_ext_s  = 32'(dwell_r);
   assign step_limit_s = TICK_U * (32'(step_r) + 32'd1) - 32'd1;
   assign face_inc_s   = (face_r == 3'd6) ? 3'd1 : face_r + 3'd1;
   assign legal_s      = (dice_in >= 3'd1) && (dice_in <= 3'd6);

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= ST_IDLE;
         target_r <= 3'd0;
         face_r   <= 3'd0;
         pips_r   <= 7'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         error_r  <= 1'b0;
         step_r   <= '0;
         dwell_r  <= '0;
      end else begin
         state_r  <= state_s;
         target_r <= target_s;
         face_r   <= face_s;
         pips_r   <= pips_s;
         busy_r   <= busy_s;
         done_r   <= done_s;
         error_r  <= error_s;
         step_r   <= step_s;
         dwell_r  <= dwell_s;
      end
   end

   // Next-state and next-output logic; loads are ignored only while rolling.
   always_comb begin
      state_s  = state_r;
      target_s = target_r;
      face_s   = face_r;
      pips_s   = pips_r;
      busy_s   = busy_r;
      done_s   = 1'b0;
      error_s  = error_r;
      step_s   = step_r;
      dwell_s  = dwell_r;
      if (dice_valid && (state_r != ST_ROLL)) begin
         step_s  = '0;
         dwell_s = '0;
         if (legal_s) begin
            state_s  = ST_ROLL;
            target_s = dice_in;
            face_s   = 3'd1;
            pips_s   = pip_map(3'd1);
            busy_s   = 1'b1;
            error_s  = 1'b0;
         end else begin
            state_s  = ST_ERROR;
            face_s   = 3'd0;
            pips_s   = 7'h7F;
            busy_s   = 1'b0;
            error_s  = 1'b1;
         end
      end else begin
         case (state_r)
            ST_ROLL: begin
               if (dwell_ext_s == step_limit_s) begin
                  dwell_s = '0;
                  if (32'(step_r) == LAST_STEP) begin
                     state_s = ST_SHOW;
                     face_s  = target_r;
                     pips_s  = pip_map(target_r);
                     busy_s  = 1'b0;
                     done_s  = 1'b1;
                  end else begin
                     step_s = step_r + STEP_W'(1);
                     face_s = face_inc_s;
                     pips_s = pip_map(face_inc_s);
                  end
               end else begin
                  dwell_s = dwell_r + DWELL_W'(1);
               end
            end
            ST_ERROR: begin
               if (dwell_ext_s == BLINK_LAST) begin
                  dwell_s = '0;
                  pips_s  = ~pips_r;
               end else begin
                  dwell_s = dwell_r + DWELL_W'(1);
               end
            end
            ST_IDLE, ST_SHOW: begin
               state_s = state_r;
            end
            default: begin
               state_s = ST_IDLE;
               face_s  = 3'd0;
               pips_s  = 7'd0;
               busy_s  = 1'b0;
               error_s = 1'b0;
            end
         endcase
      end
   end

   assign pips  = pips_r;
   assign face  = face_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign error = error_r;

endmodule
